// File: rtl/image_mem_arbiter.sv
// Single-port image memory arbiter: drawing writes, inference and display reads.
// Optional clear sequencer compiled in with IMG_CLEAR_EN.
module image_mem_arbiter #(
  parameter int GRID_SIZE = 28,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              nn_req,
  input  logic [ADDR_W-1:0] nn_addr,
  output logic              nn_gnt,
  output logic [DATA_W-1:0] nn_rdata,
  output logic              nn_rvalid,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] CELLS = ADDR_W'(GRID_SIZE * GRID_SIZE);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(GRID_SIZE * GRID_SIZE - 1);

  logic              arb_en;
  logic              in_clear;
  logic [ADDR_W-1:0] clr_addr;
  logic [1:0]        vga_wait;
  logic              boost;
  logic              nn_pend;
  logic              vga_pend;
  logic              rd_oob;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] nn_hold;
  logic [DATA_W-1:0] vga_hold;

`ifdef IMG_CLEAR_EN
  typedef enum logic {ARB, CLEAR} state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= ARB;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB:   if (clear_start) state_nx = CLEAR;
      CLEAR: if (clr_cnt == LAST) state_nx = ARB;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                clr_cnt <= '0;
    else if (state != CLEAR)  clr_cnt <= '0;
    else if (clr_cnt == LAST) clr_cnt <= '0;
    else                      clr_cnt <= clr_cnt + ADDR_W'(1);
  end

  // clear_start wins over any request in the cycle it is seen
  assign in_clear   = (state == CLEAR);
  assign clear_busy = in_clear;
  assign clr_addr   = clr_cnt;
  assign arb_en     = !reset && (state == ARB) && !clear_start;
`else
  logic unused_clear;

  assign unused_clear = clear_start;
  assign in_clear     = 1'b0;
  assign clear_busy   = 1'b0;
  assign clr_addr     = '0;
  assign arb_en       = !reset;
`endif

  assign boost = (vga_wait == 2'd3);

  always_comb begin
    wr_gnt    = arb_en & wr_req;
    nn_gnt    = arb_en & ~wr_req & nn_req & ~(boost & vga_req);
    vga_gnt   = arb_en & ~wr_req & vga_req & (boost | ~nn_req);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (1'b1)
      in_clear: begin
        mem_addr = clr_addr;
        mem_we   = 1'b1;
      end
      wr_gnt: begin
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_we    = (wr_addr < CELLS);
      end
      nn_gnt:  mem_addr = nn_addr;
      vga_gnt: mem_addr = vga_addr;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      nn_pend  <= 1'b0;
      vga_pend <= 1'b0;
      rd_oob   <= 1'b0;
      nn_hold  <= '0;
      vga_hold <= '0;
      vga_wait <= 2'd0;
    end else begin
      nn_pend  <= nn_gnt;
      vga_pend <= vga_gnt;
      if (nn_gnt | vga_gnt) rd_oob <= (mem_addr >= CELLS);
      if (nn_pend)  nn_hold  <= rd_data;
      if (vga_pend) vga_hold <= rd_data;
      if (!vga_req || vga_gnt) vga_wait <= 2'd0;
      else if (!boost)         vga_wait <= vga_wait + 2'd1;
    end
  end

  // memory data arrives the cycle after the grant; hold it afterwards
  assign rd_data    = rd_oob ? '0 : mem_rdata;
  assign nn_rvalid  = nn_pend;
  assign vga_rvalid = vga_pend;
  assign nn_rdata   = nn_pend ? rd_data : nn_hold;
  assign vga_rdata  = vga_pend ? rd_data : vga_hold;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Scoreboard bench for image_mem_arbiter: directed vectors push expected
// bus/response cycles, a negedge monitor pops and compares them.
module tb_image_mem_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        wr_req, nn_req, vga_req, clear_start;
  logic [15:0] wr_addr, nn_addr, vga_addr;
  logic [31:0] wr_data;
  logic        wr_gnt, nn_gnt, vga_gnt;
  logic [31:0] nn_rdata, vga_rdata;
  logic        nn_rvalid, vga_rvalid, clear_busy;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we;

  typedef struct packed {
    logic        wg, ng, vg, we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        nv;
    logic [31:0] nd;
    logic        vv;
    logic [31:0] vd;
    logic        busy;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    checks = 0;
  int    passed = 0;

  image_mem_arbiter dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .nn_req(nn_req), .nn_addr(nn_addr), .nn_gnt(nn_gnt),
    .nn_rdata(nn_rdata), .nn_rvalid(nn_rvalid),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // memory contents: 1 at address 5, 0x1000+addr elsewhere
  always @(posedge CLOCK_50)
    mem_rdata <= (mem_addr == 16'd5) ? 32'd1 : 32'h1000 + 32'(mem_addr);

  function automatic exp_t ex(input logic wg, ng, vg, we,
                              input logic [15:0] addr,
                              input logic [31:0] wd,
                              input logic nv, input logic [31:0] nd,
                              input logic vv, input logic [31:0] vd,
                              input logic busy);
    ex = '{wg, ng, vg, we, addr, wd, nv, nd, vv, vd, busy};
  endfunction

  function automatic logic active(input exp_t e);
    active = e.wg | e.ng | e.vg | e.we | e.nv | e.vv | e.busy;
  endfunction

  always @(negedge CLOCK_50) begin
    exp_t  got;
    exp_t  want;
    string nm;
    if (!reset) begin
      got = '{wr_gnt, nn_gnt, vga_gnt, mem_we, mem_addr, mem_wdata,
              nn_rvalid, nn_rdata, vga_rvalid, vga_rdata, clear_busy};
      if (active(got)) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_output got=%h want=none", got);
        end else begin
          want = q.pop_front();
          nm   = qn.pop_front();
          if (got === want) passed++;
          else $display("FAIL %s got=%h want=%h", nm, got, want);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s got=%h want=%h", nm, got, want);
  endtask

  task automatic step(input string nm,
                      input logic wr, input logic [15:0] wa,
                      input logic [31:0] wd,
                      input logic nr, input logic [15:0] na,
                      input logic vr, input logic [15:0] va,
                      input logic cs, input exp_t e);
    @(posedge CLOCK_50);
    #1;
    wr_req = wr; wr_addr = wa; wr_data = wd;
    nn_req = nr; nn_addr = na;
    vga_req = vr; vga_addr = va;
    clear_start = cs;
    if (active(e)) begin
      q.push_back(e);
      qn.push_back(nm);
    end
  endtask

  task automatic idle(input string nm, input exp_t e);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, e);
  endtask

  initial begin
    reset = 1'b1;
    wr_req = 1'b1; wr_addr = 16'd1; wr_data = 32'd1;
    nn_req = 1'b0; nn_addr = '0;
    vga_req = 1'b0; vga_addr = '0;
    clear_start = 1'b0;
    #2;
    chk("rst_wr_gnt", 32'(wr_gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_nn_rvalid", 32'(nn_rvalid), 0);
    chk("rst_vga_rvalid", 32'(vga_rvalid), 0);
    chk("rst_nn_rdata", nn_rdata, 0);
    chk("rst_vga_rdata", vga_rdata, 0);
    chk("rst_clear_busy", 32'(clear_busy), 0);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    wr_req = 1'b0;

    step("wr_beats_nn", 1, 29, 1, 1, 7, 0, 0, 0,
         ex(1,0,0,1, 29, 1, 0,0, 0,0, 0));
    step("nn_after_wr", 0, 0, 0, 1, 7, 0, 0, 0,
         ex(0,1,0,0, 7, 0, 0,0, 0,0, 0));
    idle("nn_rvalid_7", ex(0,0,0,0, 0, 0, 1,'h1007, 0,0, 0));
    step("nn_rd5", 0, 0, 0, 1, 5, 0, 0, 0,
         ex(0,1,0,0, 5, 0, 0,'h1007, 0,0, 0));
    step("nn_rd800", 0, 0, 0, 1, 800, 0, 0, 0,
         ex(0,1,0,0, 800, 0, 1,1, 0,0, 0));
    idle("nn_oob_zero", ex(0,0,0,0, 0, 0, 1,0, 0,0, 0));
    idle("quiet", ex(0,0,0,0, 0, 0, 0,0, 0,0, 0));

    step("boost_c1", 0, 0, 0, 1, 10, 1, 20, 0,
         ex(0,1,0,0, 10, 0, 0,0, 0,0, 0));
    step("boost_c2", 0, 0, 0, 1, 10, 1, 20, 0,
         ex(0,1,0,0, 10, 0, 1,'h100A, 0,0, 0));
    step("boost_c3", 0, 0, 0, 1, 10, 1, 20, 0,
         ex(0,1,0,0, 10, 0, 1,'h100A, 0,0, 0));
    step("boost_c4", 0, 0, 0, 1, 10, 1, 20, 0,
         ex(0,0,1,0, 20, 0, 1,'h100A, 0,0, 0));
    step("boost_c5", 0, 0, 0, 1, 10, 0, 0, 0,
         ex(0,1,0,0, 10, 0, 0,'h100A, 1,'h1014, 0));
    step("wait_cleared", 0, 0, 0, 1, 10, 1, 20, 0,
         ex(0,1,0,0, 10, 0, 1,'h100A, 0,'h1014, 0));
    idle("nn_rvalid_10", ex(0,0,0,0, 0, 0, 1,'h100A, 0,'h1014, 0));

    step("vga_rd783", 0, 0, 0, 0, 0, 1, 783, 0,
         ex(0,0,1,0, 783, 0, 0,'h100A, 0,'h1014, 0));
    idle("vga_rvalid_783", ex(0,0,0,0, 0, 0, 0,'h100A, 1,'h130F, 0));
    step("wr783_beats_vga", 1, 783, 'hABCD, 0, 0, 1, 784, 0,
         ex(1,0,0,1, 783, 'hABCD, 0,'h100A, 0,'h130F, 0));
    step("vga_rd784", 0, 0, 0, 0, 0, 1, 784, 0,
         ex(0,0,1,0, 784, 0, 0,'h100A, 0,'h130F, 0));
    step("wr784_dropped", 1, 784, 'hDEAD, 0, 0, 0, 0, 0,
         ex(1,0,0,0, 784, 'hDEAD, 0,'h100A, 1,0, 0));
    idle("quiet", ex(0,0,0,0, 0, 0, 0,0, 0,0, 0));

`ifdef IMG_CLEAR_EN
    step("clr_go", 1, 100, 'h55, 0, 0, 0, 0, 1,
         ex(0,0,0,0, 0, 0, 0,0, 0,0, 0));
    for (int i = 0; i < 784; i++)
      step("clr_wr", 1, 100, 'h55, 0, 0, 0, 0, logic'(i == 10),
           ex(0,0,0,1, 16'(i), 0, 0,'h100A, 0,0, 1));
    step("wr_after_clr", 1, 100, 'h55, 0, 0, 0, 0, 0,
         ex(1,0,0,1, 100, 'h55, 0,'h100A, 0,0, 0));
    idle("quiet", ex(0,0,0,0, 0, 0, 0,0, 0,0, 0));

    step("clr_go2", 0, 0, 0, 0, 0, 0, 0, 1,
         ex(0,0,0,0, 0, 0, 0,0, 0,0, 0));
    for (int i = 0; i < 400; i++)
      idle("clr_wr2", ex(0,0,0,1, 16'(i), 0, 0,'h100A, 0,0, 1));
    @(posedge CLOCK_50);
    #1;
    chk("clr_at_400", 32'(mem_addr), 400);
    chk("busy_at_400", 32'(clear_busy), 1);
    wr_req = 1'b1; wr_addr = 16'd3; wr_data = 32'd9;
    reset = 1'b1;
    #1;
    chk("async_busy", 32'(clear_busy), 0);
    chk("async_mem_we", 32'(mem_we), 0);
    chk("async_wr_gnt", 32'(wr_gnt), 0);
    chk("async_nn_rdata", nn_rdata, 0);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    q.push_back(ex(1,0,0,1, 3, 9, 0,0, 0,0, 0));
    qn.push_back("wr_after_reset");
`else
    step("clr_ignored", 1, 50, 7, 0, 0, 0, 0, 1,
         ex(1,0,0,1, 50, 7, 0,'h100A, 0,0, 0));
    idle("no_busy", ex(0,0,0,0, 0, 0, 0,0, 0,0, 0));
    @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
    #1;
    chk("async_nn_rdata", nn_rdata, 0);
    chk("async_busy", 32'(clear_busy), 0);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
`endif

    for (int i = 0; i < 3; i++)
      idle("drain", ex(0,0,0,0, 0, 0, 0,0, 0,0, 0));
    @(posedge CLOCK_50);
    #1;
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/image_mem_arbiter.md
IMAGE_MEM_ARBITER -- requirements
Module: image_mem_arbiter

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 28, meaning the grid edge in cells; the cell count is GRID_SIZE*GRID_SIZE (784).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning the address width of all ports.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the signed data width of all ports.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the single clock; every register is rising-edge triggered.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports wr_req (input, 1), wr_addr (input, ADDR_W), wr_data (input, DATA_W) and wr_gnt (output, 1): the drawing write requester.
REQ-007 SHALL have ports nn_req (input, 1), nn_addr (input, ADDR_W), nn_gnt (output, 1), nn_rdata (output, DATA_W) and nn_rvalid (output, 1): the inference read requester.
REQ-008 SHALL have ports vga_req (input, 1), vga_addr (input, ADDR_W), vga_gnt (output, 1), vga_rdata (output, DATA_W) and vga_rvalid (output, 1): the display read requester.
REQ-009 SHALL have ports clear_start (input, 1) and clear_busy (output, 1): the clear sequencer control.
REQ-010 SHALL have ports mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), mem_we (output, 1) and mem_rdata (input, DATA_W): the single image-memory port, with read data valid 1 cycle after the address.

Function
REQ-011 SHALL grant at most one requester per cycle; grants are combinational from the requests and the registered state, and the granted access is driven onto mem_* in that same cycle.
REQ-012 SHALL use this priority in state ARB: wr > nn > vga, except when the vga starvation boost is set (REQ-013).
- Under the boost the order is wr > vga > nn.
REQ-013 SHALL maintain a 2-bit vga_wait counter.
- Increments, saturating at 3, each cycle vga_req=1 and vga_gnt=0.
- Clears to 0 on a vga grant or when vga_req=0.
- The boost is active when vga_wait==3.
REQ-014 SHALL, on a wr grant with wr_addr < 784, drive mem_we=1, mem_addr=wr_addr and mem_wdata=wr_data.
- With wr_addr >= 784 it still asserts wr_gnt but drives mem_we=0 (the write is dropped).
REQ-015 SHALL, on a read grant, drive mem_addr to the requester's address and mem_we=0.
- One cycle later it asserts that requester's rvalid for exactly 1 cycle, with rdata = mem_rdata.
- If the address was >= 784, rdata = 0.
REQ-016 SHALL hold rdata stable until that requester's next rvalid; rvalid SHALL never assert on both read ports in the same cycle.
REQ-017 SHALL drive mem_addr=0, mem_we=0 and mem_wdata=0 when no access is granted.
REQ-018 SHALL implement FSM states ARB and CLEAR.
- ARB -> CLEAR when clear_start=1.
- CLEAR -> ARB the cycle after the write to address 783.
REQ-019 SHALL, in CLEAR, write 0 to addresses 0..783 on consecutive cycles (784 cycles) using a registered clear counter.
- clear_busy=1 throughout CLEAR.
- No grants are issued in CLEAR; pending requests wait.
REQ-020 SHALL ignore clear_start while in CLEAR.
- If clear_start and requests are both high in ARB, the clear wins and no grant is issued that cycle.
REQ-021 SHALL still deliver the rvalid of a read granted in the cycle before entering CLEAR.

Reset
REQ-022 SHALL, on reset assertion (asynchronous, any state, including mid-CLEAR), immediately set state=ARB, clear counter=0, vga_wait=0, nn_rvalid=0, vga_rvalid=0, nn_rdata=0, vga_rdata=0 and clear_busy=0.
REQ-023 SHALL force all grants and mem_we to 0 while reset=1.
- An aborted clear is not resumed after reset releases.

Configuration
REQ-024 SHALL compile the clear sequencer only when macro IMG_CLEAR_EN is defined.
- Without IMG_CLEAR_EN: state CLEAR is absent, clear_start is ignored, clear_busy is tied to 0, and arbitration is unchanged.

Verification
REQ-025 SHALL cover: wr_req=1, wr_addr=29, wr_data=1 and nn_req=1 in the same cycle -> wr_gnt=1, nn_gnt=0, mem_we=1, mem_addr=29; nn granted the next cycle.
REQ-026 SHALL cover: nn_req held high and vga_req=1 for 4 cycles -> vga_gnt=1 in the 4th cycle, vga_rvalid=1 in the 5th, vga_wait back to 0.
REQ-027 SHALL cover: nn read of addr 5 with mem_rdata=1 -> nn_rvalid=1 for 1 cycle, 1 cycle after nn_gnt, with nn_rdata=1; nn read of addr 800 -> nn_rdata=0 and nn_rvalid=1.
REQ-028 SHALL cover: clear_start pulse (IMG_CLEAR_EN defined) -> clear_busy=1 for 784 cycles, mem_we=1 with mem_wdata=0 at addresses 0..783 in order, no grants during that time, then ARB.
REQ-029 SHALL cover: reset asserted at clear count 400 -> clear_busy=0 without waiting for a clock edge; after release wr_req is granted on the first cycle.
REQ-030 SHALL cover: wr_addr=784 -> wr_gnt=1 and mem_we=0.
